// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: debug FSM states and
// EX-stage operand forwarding selects.
// Optional macro HAZ_PERF_CNT_EN (top level) does not affect this package.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } dbg_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_EM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MW = 2'b10;  // MEM/WB write-back value

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Purpose: pick the forwarding source for one EX-stage operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever the inputs are.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_em_i,
  input  logic       we_em_i,
  input  logic [4:0] rd_mw_i,
  input  logic       we_mw_i,
  output logic [1:0] sel_o
);

  // Youngest producer (EX/MEM) wins; x0 is never forwarded.
  always_comb begin
    sel_o = FWD_RF;
    if (we_em_i && (rd_em_i != 5'd0) && (rd_em_i == rs_i)) begin
      sel_o = FWD_EM;
    end else if (we_mw_i && (rd_mw_i != 5'd0) && (rd_mw_i == rs_i)) begin
      sel_o = FWD_MW;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage RV32I sequencing: load-use stall, branch flush, forwarding, debug halt/step.
// Latency: stall/flush/pc_we/fwd are combinational; halted/dbg_state are registered.
// Backpressure: a load-use stall holds IF/ID and ID/EX for one bubble; debug freeze holds until resume.
// Optional macro HAZ_PERF_CNT_EN builds saturating stall/flush counters; otherwise they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic [4:0]       RS1_DE,
  input  logic [4:0]       RS2_DE,
  input  logic [4:0]       RD_DE,
  input  logic [1:0]       MemRead_DE,
  input  logic [4:0]       RD_EM,
  input  logic             RegWrite_EM,
  input  logic [4:0]       RD_MW,
  input  logic             RegWrite_MW,
  input  logic             branch_taken_E,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  output logic             pc_we,
  output logic             flush_FD,
  output logic             flush_DE,
  output logic             stall_FD,
  output logic             stall_DE,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  dbg_state_e    state_q;
  logic [DW-1:0] cnt_q;
  logic          halted_q;
  logic          lu;

  fwd_sel u_fwd_a (
    .rs_i    (RS1_DE),
    .rd_em_i (RD_EM),
    .we_em_i (RegWrite_EM),
    .rd_mw_i (RD_MW),
    .we_mw_i (RegWrite_MW),
    .sel_o   (fwd_a_sel)
  );

  fwd_sel u_fwd_b (
    .rs_i    (RS2_DE),
    .rd_em_i (RD_EM),
    .we_em_i (RegWrite_EM),
    .rd_mw_i (RD_MW),
    .we_mw_i (RegWrite_MW),
    .sel_o   (fwd_b_sel)
  );

  // A load in EX whose destination is read by the instruction in ID needs one bubble.
  always_comb begin
    lu = (MemRead_DE != 2'b00) && (RD_DE != 5'd0) &&
         ((USE_RS1_ID && (RS1_ID == RD_DE)) || (USE_RS2_ID && (RS2_ID == RD_DE)));
  end

  // Pipeline-bank controls: branch redirect beats load-use beats debug freeze,
  // except that a frozen (HALTED) pipeline ignores any stray branch.
  always_comb begin
    pc_we    = 1'b1;
    flush_FD = 1'b0;
    flush_DE = 1'b0;
    stall_FD = 1'b0;
    stall_DE = 1'b0;
    if (!RST) begin
      unique case (state_q)
        ST_HALTED: begin
          stall_FD = 1'b1;
          stall_DE = 1'b1;
          pc_we    = 1'b0;
        end
        ST_DRAIN: begin
          if (branch_taken_E) begin
            // Latch the branch target so resume fetches from the right PC.
            flush_FD = 1'b1;
            flush_DE = 1'b1;
          end else begin
            stall_FD = 1'b1;
            stall_DE = 1'b1;
            pc_we    = 1'b0;
          end
        end
        default: begin
          if (branch_taken_E) begin
            flush_FD = 1'b1;
            flush_DE = 1'b1;
          end else if (lu) begin
            stall_FD = 1'b1;
            stall_DE = 1'b1;
            pc_we    = 1'b0;
          end
        end
      endcase
    end
  end

  // Debug FSM: RUN -> DRAIN (empty EX/MEM/WB) -> HALTED; STEP issues one instruction then drains again.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume_req) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end else if (step_req) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
          end
        end
        default: begin
          // A load-use bubble means nothing issued; keep trying to step.
          if (!(lu && !branch_taken_E)) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign halted    = halted_q;
  assign dbg_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counts of bubble cycles and flush cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (flush_DE && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if (stall_DE && !flush_DE && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// debug/reset sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 32;

  logic             CLK;
  logic             RST;
  logic [4:0]       RS1_ID, RS2_ID, RS1_DE, RS2_DE, RD_DE, RD_EM, RD_MW;
  logic             USE_RS1_ID, USE_RS2_ID, RegWrite_EM, RegWrite_MW;
  logic [1:0]       MemRead_DE;
  logic             branch_taken_E, halt_req, resume_req, step_req;
  logic             pc_we, flush_FD, flush_DE, stall_FD, stall_DE, halted;
  logic [1:0]       fwd_a_sel, fwd_b_sel, dbg_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID),
    .RS1_DE(RS1_DE), .RS2_DE(RS2_DE), .RD_DE(RD_DE), .MemRead_DE(MemRead_DE),
    .RD_EM(RD_EM), .RegWrite_EM(RegWrite_EM), .RD_MW(RD_MW), .RegWrite_MW(RegWrite_MW),
    .branch_taken_E(branch_taken_E), .halt_req(halt_req), .resume_req(resume_req),
    .step_req(step_req), .pc_we(pc_we), .flush_FD(flush_FD), .flush_DE(flush_DE),
    .stall_FD(stall_FD), .stall_DE(stall_DE), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .halted(halted), .dbg_state(dbg_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: debug mode (0 run, 1 drain, 2 halted, 3 step), drain
  // cycles already spent, and event counts.
  int m_mode = 0;
  int m_spent = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  typedef struct {
    int rs1_de, rs2_de, rd_em, we_em, rd_mw, we_mw;
    int rs1_id, rs2_id, u1, u2, rd_de, mr, br;
    int e_fa, e_fb, e_stall, e_flush, e_pc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_ref(int rs, int rd_em, int we_em, int rd_mw, int we_mw);
    if (we_em != 0 && rd_em != 0 && rd_em == rs) return 1;
    if (we_mw != 0 && rd_mw != 0 && rd_mw == rs) return 2;
    return 0;
  endfunction

  task automatic clr_in();
    RS1_ID = 0; RS2_ID = 0; USE_RS1_ID = 0; USE_RS2_ID = 0;
    RS1_DE = 0; RS2_DE = 0; RD_DE = 0; MemRead_DE = 0;
    RD_EM = 0; RegWrite_EM = 0; RD_MW = 0; RegWrite_MW = 0;
    branch_taken_E = 0; halt_req = 0; resume_req = 0; step_req = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_spent = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // One clock: compare every output with the model, clock, advance the model.
  // Called just after a falling edge with inputs already driven.
  task automatic cyc(input string tag);
    int lu, br, e_st, e_fl, e_pc, e_sc, e_fc;
    #1;
    br = int'(branch_taken_E);
    lu = (MemRead_DE != 0 && RD_DE != 0 &&
          ((USE_RS1_ID && RS1_ID == RD_DE) || (USE_RS2_ID && RS2_ID == RD_DE))) ? 1 : 0;
    e_st = 0; e_fl = 0; e_pc = 1;
    if (m_mode == 2) begin
      e_st = 1; e_pc = 0;
    end else if (br != 0) begin
      e_fl = 1;
    end else if (m_mode == 1 || lu != 0) begin
      e_st = 1; e_pc = 0;
    end
`ifdef HAZ_PERF_CNT_EN
    e_sc = m_stalls; e_fc = m_flushes;
`else
    e_sc = 0; e_fc = 0;
`endif
    chk({tag, ".stall_FD"}, int'(stall_FD), e_st);
    chk({tag, ".stall_DE"}, int'(stall_DE), e_st);
    chk({tag, ".flush_FD"}, int'(flush_FD), e_fl);
    chk({tag, ".flush_DE"}, int'(flush_DE), e_fl);
    chk({tag, ".pc_we"}, int'(pc_we), e_pc);
    chk({tag, ".fwd_a"}, int'(fwd_a_sel), fwd_ref(RS1_DE, RD_EM, RegWrite_EM, RD_MW, RegWrite_MW));
    chk({tag, ".fwd_b"}, int'(fwd_b_sel), fwd_ref(RS2_DE, RD_EM, RegWrite_EM, RD_MW, RegWrite_MW));
    chk({tag, ".dbg_state"}, int'(dbg_state), m_mode);
    chk({tag, ".halted"}, int'(halted), (m_mode == 2) ? 1 : 0);
    chk({tag, ".stall_cnt"}, int'(stall_cnt), e_sc);
    chk({tag, ".flush_cnt"}, int'(flush_cnt), e_fc);
    @(posedge CLK);
    if (e_fl != 0) m_flushes++;
    else if (e_st != 0) m_stalls++;
    case (m_mode)
      0: if (halt_req) begin m_mode = 1; m_spent = 0; end
      1: begin
        m_spent++;
        if (m_spent == DRAIN_CYCLES) m_mode = 2;
      end
      2: if (resume_req) m_mode = 0; else if (step_req) m_mode = 3;
      default: if (!(lu != 0 && br == 0)) begin m_mode = 1; m_spent = 0; end
    endcase
    @(negedge CLK);
  endtask

  // Directed expectations written straight from the test plan.
  task automatic exp_ctl(input string n, input int st, input int fl, input int pc, input int ds);
    #1;
    chk({n, ".stall"}, int'(stall_FD & stall_DE) | int'(stall_FD ^ stall_DE) << 1, st);
    chk({n, ".flush"}, int'(flush_FD & flush_DE) | int'(flush_FD ^ flush_DE) << 1, fl);
    chk({n, ".pc_we"}, int'(pc_we), pc);
    chk({n, ".dbg_state"}, int'(dbg_state), ds);
  endtask

  initial begin
    //            rs1 rs2 rem wem rmw wmw i1 i2 u1 u2 rdd mr br  fa fb st fl pc
    tbl[0]  = '{5, 0, 5, 1, 5, 1,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1};
    tbl[1]  = '{5, 0, 0, 1, 5, 1,  0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1};
    tbl[2]  = '{3, 3, 3, 0, 3, 1,  0, 0, 0, 0, 0, 0, 0,  2, 2, 0, 0, 1};
    tbl[3]  = '{4, 6, 6, 1, 4, 1,  0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0,  0, 7, 0, 1, 7, 1, 0,  0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 7, 1, 0,  0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0,  9, 0, 1, 0, 9, 2, 0,  0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,  0, 7, 0, 1, 7, 1, 1,  0, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0,  9, 9, 1, 1, 9, 3, 0,  0, 0, 1, 0, 0};

    // Reset: hazards present on the inputs must not leak through.
    clr_in();
    RST = 1'b1;
    MemRead_DE = 2'b01; RD_DE = 5'd7; RS2_ID = 5'd7; USE_RS2_ID = 1'b1; branch_taken_E = 1'b1;
    #12;
    chk("rst.flush_FD", int'(flush_FD), 0);
    chk("rst.flush_DE", int'(flush_DE), 0);
    chk("rst.stall_FD", int'(stall_FD), 0);
    chk("rst.stall_DE", int'(stall_DE), 0);
    chk("rst.pc_we", int'(pc_we), 1);
    chk("rst.fwd_a", int'(fwd_a_sel), 0);
    chk("rst.fwd_b", int'(fwd_b_sel), 0);
    chk("rst.dbg_state", int'(dbg_state), 0);
    chk("rst.halted", int'(halted), 0);
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    @(negedge CLK);
    clr_in();
    RST = 1'b0;
    model_reset();

    // Directed vector table, all in RUN.
    for (int i = 0; i < 12; i++) begin
      RS1_DE = 5'(tbl[i].rs1_de); RS2_DE = 5'(tbl[i].rs2_de);
      RD_EM = 5'(tbl[i].rd_em); RegWrite_EM = tbl[i].we_em[0];
      RD_MW = 5'(tbl[i].rd_mw); RegWrite_MW = tbl[i].we_mw[0];
      RS1_ID = 5'(tbl[i].rs1_id); RS2_ID = 5'(tbl[i].rs2_id);
      USE_RS1_ID = tbl[i].u1[0]; USE_RS2_ID = tbl[i].u2[0];
      RD_DE = 5'(tbl[i].rd_de); MemRead_DE = 2'(tbl[i].mr); branch_taken_E = tbl[i].br[0];
      #1;
      chk($sformatf("vec%0d.fwd_a", i), int'(fwd_a_sel), tbl[i].e_fa);
      chk($sformatf("vec%0d.fwd_b", i), int'(fwd_b_sel), tbl[i].e_fb);
      chk($sformatf("vec%0d.stall", i), int'(stall_FD) + int'(stall_DE), 2 * tbl[i].e_stall);
      chk($sformatf("vec%0d.flush", i), int'(flush_FD) + int'(flush_DE), 2 * tbl[i].e_flush);
      chk($sformatf("vec%0d.pc_we", i), int'(pc_we), tbl[i].e_pc);
      cyc($sformatf("vec%0d", i));
    end

    // Load-use bubble releases itself once the bubble clears MemRead_DE.
    clr_in();
    MemRead_DE = 2'b01; RD_DE = 5'd7; RS2_ID = 5'd7; USE_RS2_ID = 1'b1;
    exp_ctl("lu", 1, 0, 0, 0); cyc("lu");
    MemRead_DE = 2'b00;
    exp_ctl("lu.rel", 0, 0, 1, 0); cyc("lu.rel");

    // Halt with a branch resolving in the first drain cycle.
    clr_in();
    halt_req = 1'b1;
    exp_ctl("halt.run", 0, 0, 1, 0); cyc("halt.run");
    halt_req = 1'b0; branch_taken_E = 1'b1;
    exp_ctl("drain0.br", 0, 1, 1, 1); cyc("drain0.br");
    branch_taken_E = 1'b0;
    exp_ctl("drain1", 1, 0, 0, 1); cyc("drain1");
    exp_ctl("drain2", 1, 0, 0, 1); cyc("drain2");
    exp_ctl("halted", 1, 0, 0, 2);
    chk("halted.flag", int'(halted), 1);
    cyc("halted");

    // Single step, then drain back to HALTED.
    step_req = 1'b1;
    exp_ctl("halt.step", 1, 0, 0, 2); cyc("halt.step");
    step_req = 1'b0;
    exp_ctl("step", 0, 0, 1, 3); cyc("step");
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      exp_ctl($sformatf("sdrain%0d", i), 1, 0, 0, 1); cyc("sdrain");
    end
    exp_ctl("shalted", 1, 0, 0, 2);
    chk("shalted.flag", int'(halted), 1);

    // Resume wins over step; a held halt_req re-enters DRAIN right away.
    step_req = 1'b1; resume_req = 1'b1; halt_req = 1'b1;
    cyc("resume");
    step_req = 1'b0; resume_req = 1'b0;
    exp_ctl("resume.run", 0, 0, 1, 0); cyc("resume.run");
    halt_req = 1'b0;
    exp_ctl("rehalt", 1, 0, 0, 1); cyc("rehalt");

    // Asynchronous reset in the middle of DRAIN.
    #2 RST = 1'b1;
    #1;
    chk("arst.dbg_state", int'(dbg_state), 0);
    chk("arst.halted", int'(halted), 0);
    chk("arst.pc_we", int'(pc_we), 1);
    chk("arst.stall_DE", int'(stall_DE), 0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

`ifdef HAZ_PERF_CNT_EN
    // Four load-use bubbles counted, then cleared by reset.
    MemRead_DE = 2'b01; RD_DE = 5'd7; RS2_ID = 5'd7; USE_RS2_ID = 1'b1;
    for (int i = 0; i < 4; i++) cyc("perf.lu");
    clr_in();
    #1;
    chk("perf.stall_cnt4", int'(stall_cnt), 4);
    RST = 1'b1;
    #1;
    chk("perf.stall_cnt0", int'(stall_cnt), 0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      RS1_ID = 5'($urandom_range(0, 3)); RS2_ID = 5'($urandom_range(0, 3));
      USE_RS1_ID = 1'($urandom); USE_RS2_ID = 1'($urandom);
      RS1_DE = 5'($urandom_range(0, 3)); RS2_DE = 5'($urandom_range(0, 3));
      RD_DE = 5'($urandom_range(0, 3));
      MemRead_DE = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      RD_EM = 5'($urandom_range(0, 3)); RegWrite_EM = 1'($urandom);
      RD_MW = 5'($urandom_range(0, 3)); RegWrite_MW = 1'($urandom);
      branch_taken_E = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      resume_req = ($urandom_range(0, 7) == 0);
      step_req = ($urandom_range(0, 5) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core; drives the IF/ID and ID/EX flush/stall inputs of the pipeline register bank and the PC write-enable.
- Detects load-use hazards, applies branch-redirect flushes, and generates EX-stage forwarding selects.
- Contains a debug halt/step FSM that drains EX/MEM/WB before reporting halted.

Parameters:
- DRAIN_CYCLES, 3, cycles of bubble insertion needed to empty EX, MEM and WB after fetch stops.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- RS1_ID, RS2_ID  in  5 each  source registers of the instruction in ID.
- USE_RS1_ID, USE_RS2_ID  in  1 each  instruction in ID actually reads rs1 / rs2.
- RS1_DE, RS2_DE  in  5 each  source registers in EX.
- RD_DE  in  5; MemRead_DE  in  2 (nonzero = load in EX).
- RD_EM  in  5; RegWrite_EM  in  1.
- RD_MW  in  5; RegWrite_MW  in  1.
- branch_taken_E  in  1  taken branch/jump resolved in EX this cycle.
- halt_req, resume_req, step_req  in  1 each  debug requests, level-sampled.
- pc_we  out  1  PC register load enable.
- flush_FD, flush_DE, stall_FD, stall_DE  out  1 each  to the pipeline register bank.
- fwd_a_sel, fwd_b_sel  out  2 each  00 = register file, 01 = EX/MEM ALU value, 10 = MEM/WB write-back value.
- halted  out  1  pipeline drained and frozen.
- dbg_state  out  2  current FSM state.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset state: RUN, drain counter 0, and halted=0. Counters are 0.
  - All flush and stall outputs are 0 while RST is high.
  - pc_we=1; fwd selects 00.
- Forwarding is purely combinational, and EM has priority over MW.
  - fwd_a_sel = 01 if RegWrite_EM && RD_EM!=0 && RD_EM==RS1_DE.
  - Otherwise fwd_a_sel = 10 if RegWrite_MW && RD_MW!=0 && RD_MW==RS1_DE.
  - Otherwise fwd_a_sel = 00.
  - fwd_b_sel follows the same rules using RS2_DE.
- Load-use detection is combinational:
  - lu = MemRead_DE!=0 && RD_DE!=0 && ((USE_RS1_ID && RS1_ID==RD_DE) || (USE_RS2_ID && RS2_ID==RD_DE)).
- Output priority in the same cycle: branch redirect > load-use > debug freeze.
  - branch_taken_E: flush_FD=1, flush_DE=1, pc_we=1, stall_*=0. This applies in every state except HALTED.
  - lu (no branch): stall_FD=1, stall_DE=1 (one bubble), pc_we=0. It releases itself the next cycle because the bubble clears MemRead_DE.
- FSM states: RUN=0, DRAIN=1, HALTED=2, STEP=3.
  - RUN: normal operation. halt_req goes to DRAIN with counter=0, including when lu or branch_taken_E is active that cycle.
  - DRAIN: outputs stall_FD=1, stall_DE=1, pc_we=0, unless branch_taken_E overrides (flush plus pc_we=1 so the target is latched for resume).
    - The counter increments each cycle.
    - At counter==DRAIN_CYCLES-1 the FSM goes to HALTED.
    - The instruction held in IF/ID is re-issued on resume.
  - HALTED: stall_FD=1, stall_DE=1, pc_we=0, halted=1. branch_taken_E cannot be asserted here; if it is, it is ignored.
    - resume_req goes to RUN.
    - Else step_req goes to STEP.
    - resume_req has priority when both are high.
  - STEP: normal advance for one cycle, then DRAIN.
    - If lu is active in the STEP cycle, the FSM stays in STEP because nothing was issued.
- halt_req held high in RUN after resume: re-enters DRAIN on the next cycle.
- RST asserted mid-DRAIN or mid-STEP: immediate return to RUN, counter cleared.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall_DE=1 and flush_DE=0.
  - flush_cnt increments on every cycle with flush_DE=1.
  - Both counters saturate at all-ones and are cleared by RST.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - FSM state encodings (ST_RUN, ST_DRAIN, ST_HALTED, ST_STEP).
  - Forwarding select constants (FWD_RF=2'b00, FWD_EM=2'b01, FWD_MW=2'b10).
- One combinational sub-module, fwd_sel, instantiated twice (operand A and operand B). It takes rs, RD_EM, RegWrite_EM, RD_MW and RegWrite_MW, and returns the 2-bit select.

Test Plan:
- Forwarding: RD_EM=5, RegWrite_EM=1, RD_MW=5, RegWrite_MW=1, RS1_DE=5 → fwd_a_sel=01. Same with RD_EM=0 → fwd_a_sel=10.
- Load-use: MemRead_DE=2'b01, RD_DE=7, RS2_ID=7, USE_RS2_ID=1 → one cycle with stall_FD=1, stall_DE=1, pc_we=0; the next cycle (MemRead_DE=0) all stalls are 0.
- Priority: branch_taken_E=1 together with a load-use condition → flush_FD=1, flush_DE=1, pc_we=1, stall_FD=0, stall_DE=0.
- Halt drain: pulse halt_req in RUN → 3 cycles in DRAIN with stall_FD=1, stall_DE=1, then halted=1 and dbg_state=2.
  - With branch_taken_E=1 in the first DRAIN cycle → flush outputs and pc_we=1 that cycle, still HALTED after 3 cycles.
- Step: in HALTED assert step_req → one STEP cycle with pc_we=1 and no stalls, then 3 DRAIN cycles, then HALTED.
  - step_req and resume_req together → RUN.
- Reset: assert RST asynchronously mid-DRAIN → dbg_state=0, halted=0, pc_we=1 immediately.
  - With HAZ_PERF_CNT_EN: 4 load-use stalls then RST → stall_cnt goes to 4, then 0.
